// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine change dispenser.
// Denomination codes, their rupee values, payout search order and FSM states.
package vm_pkg;

  typedef enum logic [2:0] {
    D10  = 3'b000,
    D20  = 3'b001,
    D50  = 3'b010,
    D100 = 3'b011,
    D200 = 3'b100,
    D500 = 3'b101,
    D5   = 3'b110
  } denom_e;

  localparam int unsigned NUM_DENOM = 7;
  localparam int unsigned VALUE_W   = 10;

  // Indexed directly by the 3-bit code; code 111 is unused and worth nothing.
  localparam logic [VALUE_W-1:0] DENOM_VALUE [8] = '{
    10'd10, 10'd20, 10'd50, 10'd100, 10'd200, 10'd500, 10'd5, 10'd0
  };

  localparam denom_e SEARCH_ORDER [NUM_DENOM] = '{
    D500, D200, D100, D50, D20, D10, D5
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE
  } disp_state_e;

endpackage

// File: rtl/change_denom_select.sv
// Combinational greedy picker: largest in-stock denomination not exceeding
// the remaining change.
module change_denom_select
  import vm_pkg::*;
#(
  parameter int unsigned CHANGE_W = 10
) (
  input  logic [CHANGE_W-1:0]  remaining_i,
  input  logic [NUM_DENOM-1:0] avail_i,
  output logic                 found_o,
  output denom_e               denom_o
);

  always_comb begin
    found_o = 1'b0;
    denom_o = D10;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      if (!found_o && avail_i[SEARCH_ORDER[i]] &&
          (32'(DENOM_VALUE[SEARCH_ORDER[i]]) <= 32'(remaining_i))) begin
        found_o = 1'b1;
        denom_o = SEARCH_ORDER[i];
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out vend change one denomination at a time over a valid/ready hopper
// handshake. Optional HOPPER_TIMEOUT_EN adds a ready timeout and a jam pulse.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned CHANGE_W       = 10,
  parameter int unsigned STOCK_W        = 6,
  parameter int unsigned STOCK_INIT     = 8
`ifdef HOPPER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vend,
  input  logic [CHANGE_W-1:0] change_in,
  input  logic                refill,
  output logic                disp_valid,
  output logic [2:0]          disp_denom,
  input  logic                disp_ready,
  output logic                busy,
  output logic                done,
  output logic [CHANGE_W-1:0] short_amt,
  output logic                overrun
`ifdef HOPPER_TIMEOUT_EN
  ,
  output logic                jam
`endif
);

  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_INIT);

  disp_state_e         state_q, state_d;
  logic [CHANGE_W-1:0] remaining_q, remaining_d;
  logic [STOCK_W-1:0]  stock_q [NUM_DENOM];
  logic [STOCK_W-1:0]  stock_d [NUM_DENOM];
  denom_e              denom_q, denom_d;
  logic [CHANGE_W-1:0] short_q, short_d;
  logic                overrun_q, overrun_d;

  logic [NUM_DENOM-1:0] avail;
  logic                 pick_found;
  denom_e               pick_denom;

`ifdef HOPPER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             jam_d;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      avail[i] = (stock_q[i] != '0);
    end
  end

  change_denom_select #(
    .CHANGE_W (CHANGE_W)
  ) u_select (
    .remaining_i (remaining_q),
    .avail_i     (avail),
    .found_o     (pick_found),
    .denom_o     (pick_denom)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    stock_d     = stock_q;
    denom_d     = denom_q;
    short_d     = short_q;
    overrun_d   = vend && (state_q != S_IDLE);
`ifdef HOPPER_TIMEOUT_EN
    tmo_d       = '0;
    jam_d       = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (refill) begin
          for (int unsigned i = 0; i < NUM_DENOM; i++) begin
            stock_d[i] = STOCK_FULL;
          end
        end
        if (vend) begin
          remaining_d = change_in;
          short_d     = '0;
          state_d     = S_SELECT;
        end
      end

      S_SELECT: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (pick_found) begin
          denom_d = pick_denom;
          state_d = S_ISSUE;
        end else begin
          short_d = remaining_q;
          state_d = S_DONE;
        end
      end

      S_ISSUE: begin
        if (disp_ready) begin
          // The picker guarantees value <= remaining, so no underflow here.
          remaining_d = remaining_q - CHANGE_W'(DENOM_VALUE[denom_q]);
          for (int unsigned i = 0; i < NUM_DENOM; i++) begin
            if (3'(i) == denom_q && stock_q[i] != '0) begin
              stock_d[i] = stock_q[i] - 1'b1;
            end
          end
          state_d = S_SELECT;
        end
`ifdef HOPPER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          jam_d = 1'b1;
          for (int unsigned i = 0; i < NUM_DENOM; i++) begin
            if (3'(i) == denom_q) begin
              stock_d[i] = '0;
            end
          end
          state_d = S_SELECT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      for (int unsigned i = 0; i < NUM_DENOM; i++) begin
        stock_q[i] <= STOCK_FULL;
      end
      denom_q     <= D10;
      short_q     <= '0;
      overrun_q   <= 1'b0;
`ifdef HOPPER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      stock_q     <= stock_d;
      denom_q     <= denom_d;
      short_q     <= short_d;
      overrun_q   <= overrun_d;
`ifdef HOPPER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign disp_valid = (state_q == S_ISSUE);
  assign disp_denom = denom_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign short_amt  = short_q;
  assign overrun    = overrun_q;
`ifdef HOPPER_TIMEOUT_EN
  assign jam        = jam_d;
`endif

endmodule
